// File: rtl/parking_pkg.sv
// Shared types and constants for the parking occupancy counter slice.
package parking_pkg;

  localparam int WIDTH_DEFAULT    = 4;
  localparam int CAPACITY_DEFAULT = 12;

  typedef struct packed {
    logic enter_ev;
    logic exit_ev;
  } event_pair_t;

  function automatic logic [31:0] width_mask(input int width);
    return (width >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << width) - 64'd1);
  endfunction

  // Adder operand encodings: +1, -1 (all ones, two's complement) and 0.
  function automatic logic [31:0] delta_inc(input int width);
    return 32'd1 & width_mask(width);
  endfunction

  function automatic logic [31:0] delta_dec(input int width);
    return width_mask(width);
  endfunction

  function automatic logic [31:0] delta_zero(input int width);
    return 32'd0 & width_mask(width);
  endfunction

endpackage

// File: rtl/parking_occupancy_counter_if.sv
// Sensor inputs and status/pulse outputs between the lot sensors, counter and gate/display.
interface parking_occupancy_counter_if #(
  parameter int WIDTH = parking_pkg::WIDTH_DEFAULT
);
  logic             car_enter;
  logic             car_exit;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] free;
  logic             full;
  logic             empty;
  logic             entry_grant;
  logic             entry_deny;
  logic             exit_error;

  modport master (
    output car_enter, car_exit,
    input  count, free, full, empty, entry_grant, entry_deny, exit_error
  );

  modport slave (
    input  car_enter, car_exit,
    output count, free, full, empty, entry_grant, entry_deny, exit_error
  );
endinterface

// File: rtl/parking_occupancy_counter_ripple_adder.sv
// Ripple-carry adder built from a generate chain of full_adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  logic [WIDTH:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a        (a[i]),
      .b        (b[i]),
      .carry_in (carry[i]),
      .sum      (sum[i]),
      .carry_out(carry[i+1])
    );
  end

  assign carry_out = carry[WIDTH];
endmodule

// File: rtl/parking_occupancy_counter.sv
// Occupancy counter: edge-detects entry/exit sensors, grants/denies entries, flags illegal exits.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int CAPACITY = CAPACITY_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  parking_occupancy_counter_if.slave bus
);

  if (CAPACITY < 1 || CAPACITY > (2 ** WIDTH) - 1) begin : g_bad_capacity
    $error("parking_occupancy_counter: CAPACITY out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] CAP_W      = WIDTH'(CAPACITY);
  localparam logic [WIDTH-1:0] DELTA_INC  = WIDTH'(delta_inc(WIDTH));
  localparam logic [WIDTH-1:0] DELTA_DEC  = WIDTH'(delta_dec(WIDTH));
  localparam logic [WIDTH-1:0] DELTA_ZERO = WIDTH'(delta_zero(WIDTH));

  logic             enter_prev, exit_prev;
  logic [WIDTH-1:0] count_r, free_r;
  logic             full_r, empty_r, grant_r, deny_r, error_r;

  event_pair_t      ev;
  logic [WIDTH-1:0] delta, next_count, next_free;
  logic             grant_c, deny_c, error_c;
  logic             carry_unused_count, carry_unused_free;

  assign ev.enter_ev = bus.car_enter & ~enter_prev;
  assign ev.exit_ev  = bus.car_exit & ~exit_prev;

  always_comb begin
    delta   = DELTA_ZERO;
    grant_c = 1'b0;
    deny_c  = 1'b0;
    error_c = 1'b0;
    case (ev)
      2'b01: begin
        if (count_r != '0) delta = DELTA_DEC;
        else               error_c = 1'b1;
      end
      2'b10: begin
        if (count_r < CAP_W) begin
          grant_c = 1'b1;
          delta   = DELTA_INC;
        end else begin
          deny_c = 1'b1;
        end
      end
      2'b11: begin
        // A legal exit frees a space for the simultaneous entry, even when full.
        grant_c = 1'b1;
        if (count_r == '0) begin
          error_c = 1'b1;
          delta   = DELTA_INC;
        end
      end
      default: ;
    endcase
  end

  ripple_adder #(.WIDTH(WIDTH)) u_count_add (
    .a        (count_r),
    .b        (delta),
    .carry_in (1'b0),
    .sum      (next_count),
    .carry_out(carry_unused_count)
  );

  ripple_adder #(.WIDTH(WIDTH)) u_free_add (
    .a        (CAP_W),
    .b        (~next_count),
    .carry_in (1'b1),
    .sum      (next_free),
    .carry_out(carry_unused_free)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enter_prev <= 1'b1;
      exit_prev  <= 1'b1;
      count_r    <= '0;
      free_r     <= CAP_W;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      grant_r    <= 1'b0;
      deny_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      enter_prev <= bus.car_enter;
      exit_prev  <= bus.car_exit;
      count_r    <= next_count;
      free_r     <= next_free;
      full_r     <= (next_count == CAP_W);
      empty_r    <= (next_count == '0);
      grant_r    <= grant_c;
      deny_r     <= deny_c;
      error_r    <= error_c;
    end
  end

  assign bus.count       = count_r;
  assign bus.free        = free_r;
  assign bus.full        = full_r;
  assign bus.empty       = empty_r;
  assign bus.entry_grant = grant_r;
  assign bus.entry_deny  = deny_r;
  assign bus.exit_error  = error_r;

  a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count_r <= CAP_W);

endmodule
